// File: rtl/dmem_pkg.sv
// Shared defaults, FSM state codes and the byte-merge helper for dmem_responder.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W     = 8;
    localparam int unsigned DMEM_DATA_W     = 32;
    localparam int unsigned DMEM_DEPTH      = 256;
    localparam int unsigned DMEM_RD_LAT     = 1;

    // Widest word the merge helper handles; callers cast to/from their own width.
    localparam int unsigned DMEM_MAX_DATA_W = 256;
    localparam int unsigned DMEM_MAX_MASK_W = DMEM_MAX_DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Replace each byte of old_word whose mask bit is set with the byte of new_word.
    function automatic logic [DMEM_MAX_DATA_W-1:0] byte_merge(
        input logic [DMEM_MAX_DATA_W-1:0] old_word,
        input logic [DMEM_MAX_DATA_W-1:0] new_word,
        input logic [DMEM_MAX_MASK_W-1:0] mask
    );
        logic [DMEM_MAX_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < int'(DMEM_MAX_MASK_W); b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-data delay line: RD_LAT data stages, each loaded only when a read reaches it,
// so the final stage (dout) holds its last value between reads.
module dmem_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [DATA_W-1:0] out_data_o
);

    // Per-stage load enables; stage 0 loads on a new read, later stages follow the valid chain.
    logic [RD_LAT-1:0]             ld;
    logic [RD_LAT:0][DATA_W-1:0]   chain;

    assign ld[0]    = in_valid_i;
    assign chain[0] = in_data_i;

    if (RD_LAT > 1) begin : g_vld
        logic [RD_LAT-2:0] vld_q;

        // Valid shift register; the last data stage needs no valid of its own.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                vld_q <= '0;
            end else begin
                vld_q <= (RD_LAT-1)'({vld_q, in_valid_i});
            end
        end

        assign ld[RD_LAT-1:1] = vld_q;
    end

    for (genvar s = 0; s < int'(RD_LAT); s++) begin : g_stage
        logic [DATA_W-1:0] dat_q;

        // Data stage s captures the previous stage only when a read is passing through.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                dat_q <= '0;
            end else if (ld[s]) begin
                dat_q <= chain[s];
            end
        end

        assign chain[s+1] = dat_q;
    end

    assign out_data_o = chain[RD_LAT];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-fills after reset, then serves byte-masked core writes,
// full-word init preloads and fixed-latency write-first reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned DEPTH  = DMEM_DEPTH,
    parameter int unsigned RD_LAT = DMEM_RD_LAT
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                csb_write_i,
    input  logic [DATA_W/8-1:0] wmask_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   din_i,
    input  logic                csb_read_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   dout_o,
    output logic                mem_ready_o,
    input  logic                init_valid_i,
    output logic                init_ready_o,
    input  logic [ADDR_W-1:0]   init_addr_i,
    input  logic [DATA_W-1:0]   init_data_i
);

    localparam int unsigned MASK_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_nxt;

    logic              idle;
    logic              waddr_ok;
    logic              raddr_ok;
    logic              iaddr_ok;
    logic              wr_fire;
    logic              init_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_data;

    // Address range checks collapse to constants when the array fills the address space.
    if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
        assign waddr_ok = 1'b1;
        assign raddr_ok = 1'b1;
        assign iaddr_ok = 1'b1;
    end else begin : g_part_range
        assign waddr_ok = (waddr_i     < ADDR_W'(DEPTH));
        assign raddr_ok = (raddr_i     < ADDR_W'(DEPTH));
        assign iaddr_ok = (init_addr_i < ADDR_W'(DEPTH));
    end

    assign idle         = (state_q == ST_IDLE);
    assign mem_ready_o  = idle;
    assign init_ready_o = idle & csb_write_i;
    assign wr_fire      = idle & ~csb_write_i & waddr_ok;
    assign init_fire    = init_valid_i & init_ready_o & iaddr_ok;
    assign rd_fire      = idle & ~csb_read_i;

    assign wr_word = DATA_W'(byte_merge(DMEM_MAX_DATA_W'(mem[waddr_i]),
                                        DMEM_MAX_DATA_W'(din_i),
                                        DMEM_MAX_MASK_W'(wmask_i)));

    // State and clear-pointer registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_nxt;
            clr_ptr_q <= clr_ptr_nxt;
        end
    end

    // Next state: walk the clear pointer across the array, then sit in IDLE.
    always_comb begin
        state_nxt   = state_q;
        clr_ptr_nxt = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_nxt = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = ST_IDLE;
                    clr_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Storage writes: zero-fill during CLEAR, otherwise core write or init preload.
    always_ff @(posedge clk_i) begin
        if (!idle) begin
            mem[clr_ptr_q] <= '0;
        end else begin
            if (wr_fire) begin
                mem[waddr_i] <= wr_word;
            end
            if (init_fire) begin
                mem[init_addr_i] <= init_data_i;
            end
        end
    end

    // Write-first read word: same-edge writes to the read address are forwarded.
    always_comb begin
        rd_data = '0;
        if (raddr_ok) begin
            rd_data = mem[raddr_i];
            if (wr_fire && (waddr_i == raddr_i)) begin
                rd_data = wr_word;
            end else if (init_fire && (init_addr_i == raddr_i)) begin
                rd_data = init_data_i;
            end
        end
    end

    dmem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_valid_i (rd_fire),
        .in_data_i  (rd_data),
        .out_data_o (dout_o)
    );

    logic [MASK_W-1:0] unused_mask_w;
    assign unused_mask_w = '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (read latency 1 and 3) share stimulus;
// a word-level memory model predicts read data and readiness, a negedge monitor compares.
module tb_dmem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 256;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cw;
    logic [3:0]    wm;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          cr;
    logic [AW-1:0] ra;
    logic          iv;
    logic [AW-1:0] ia;
    logic [DW-1:0] idt;

    logic [DW-1:0] dout1, dout3;
    logic          rdy1, rdy3, irdy1, irdy3;

    exp_t          q1[$];
    exp_t          q3[$];
    exp_t          mon_e;
    logic [31:0]   ref_mem [DEPTH];
    int            clear_left;
    int            edge_n = 0;
    logic [31:0]   cur1, cur3;
    int            tests = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .clk_i(clk), .reset_i(rst_n),
        .csb_write_i(cw), .wmask_i(wm), .waddr_i(wa), .din_i(wd),
        .csb_read_i(cr), .raddr_i(ra), .dout_o(dout1), .mem_ready_o(rdy1),
        .init_valid_i(iv), .init_ready_o(irdy1), .init_addr_i(ia), .init_data_i(idt)
    );

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(3)) dut3 (
        .clk_i(clk), .reset_i(rst_n),
        .csb_write_i(cw), .wmask_i(wm), .waddr_i(wa), .din_i(wd),
        .csb_read_i(cr), .raddr_i(ra), .dout_o(dout3), .mem_ready_o(rdy3),
        .init_valid_i(iv), .init_ready_o(irdy3), .init_addr_i(ia), .init_data_i(idt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Monitor: retire due read results, then compare every observable output.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q1.size() > 0 && q1[0].due <= edge_n) begin
                mon_e = q1.pop_front();
                cur1  = mon_e.data;
            end
            while (q3.size() > 0 && q3[0].due <= edge_n) begin
                mon_e = q3.pop_front();
                cur3  = mon_e.data;
            end
            check("dout_lat1", dout1, cur1);
            check("dout_lat3", dout3, cur3);
            check("mem_ready_lat1", 32'(rdy1), 32'(clear_left == 0));
            check("mem_ready_lat3", 32'(rdy3), 32'(clear_left == 0));
            check("init_ready_lat1", 32'(irdy1), 32'((clear_left == 0) && cw));
            check("init_ready_lat3", 32'(irdy3), 32'((clear_left == 0) && cw));
        end
    end

    // One clock of stimulus; the model applies the edge's effects, writes before reads.
    task automatic do_cycle(input logic c_w, input logic [3:0] m, input logic [7:0] w_a,
                            input logic [31:0] d, input logic c_r, input logic [7:0] r_a,
                            input logic i_v, input logic [7:0] i_a, input logic [31:0] i_d);
        exp_t e;
        cw = c_w; wm = m; wa = w_a; wd = d; cr = c_r; ra = r_a; iv = i_v; ia = i_a; idt = i_d;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                if (!c_w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m[b]) ref_mem[w_a][8*b +: 8] = d[8*b +: 8];
                    end
                end
                if (i_v && c_w) ref_mem[i_a] = i_d;
                if (!c_r) begin
                    e.data = ref_mem[r_a];
                    e.due  = edge_n;
                    q1.push_back(e);
                    e.due  = edge_n + 2;
                    q3.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        do_cycle(1'b0, m, a, d, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        do_cycle(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, a, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic rand_cycle(input int addr_span);
        logic [7:0] a0, a1, a2;
        a0 = ($urandom % 4 == 0) ? 8'($urandom % 256) : 8'($urandom % addr_span);
        a1 = ($urandom % 4 == 0) ? 8'($urandom % 256) : 8'($urandom % addr_span);
        a2 = 8'($urandom % addr_span);
        do_cycle(($urandom % 3) != 0, 4'($urandom), a0, $urandom,
                 ($urandom % 2) != 0, a1, ($urandom % 3) == 0, a2, $urandom);
    endtask

    // Assert reset between edges; in-flight reads are dropped and the model restarts the clear.
    task automatic reset_dut();
        rst_n = 1'b0;
        q1.delete();
        q3.delete();
        cur1 = '0;
        cur3 = '0;
        clear_left = DEPTH;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        #1;
        check("reset_dout_lat1", dout1, 32'h0);
        check("reset_dout_lat3", dout3, 32'h0);
        check("reset_ready", 32'({rdy1, rdy3, irdy1, irdy3}), 32'h0);
        idle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cw = 1'b1; wm = '0; wa = '0; wd = '0; cr = 1'b1; ra = '0; iv = 1'b0; ia = '0; idt = '0;
        rst_n = 1'b0;
        cur1 = '0;
        cur3 = '0;
        #1;
        mon_en = 1'b1;
        reset_dut();

        // Zero-fill window, then reads of the boundary words.
        idle(DEPTH);
        rd(8'd0); rd(8'd128); rd(8'd255);
        idle(4);

        // Full write followed by a single-byte overwrite.
        wr(8'd5, 32'hDEADBEEF, 4'b1111);
        wr(8'd5, 32'h000000AA, 4'b0001);
        rd(8'd5);
        idle(4);

        // Preload via init, then same-edge partial write and read of that word.
        do_cycle(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1, 8'd9, 32'hAAAAAAAA);
        do_cycle(1'b0, 4'b1100, 8'd9, 32'h12345678, 1'b0, 8'd9, 1'b0, 8'h00, 32'h0);
        idle(4);

        // Init stalled by a (mask-0) core write, accepted once the write stops.
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'h0, 8'd20, 32'hFFFFFFFF, 1'b1, 8'h00, 1'b1, 8'd30, 32'hC0FFEE01);
        do_cycle(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1, 8'd30, 32'hC0FFEE01);
        rd(8'd30); rd(8'd20);
        idle(4);

        // Back-to-back reads of three distinct words.
        wr(8'd1, 32'h11, 4'hF); wr(8'd2, 32'h22, 4'hF); wr(8'd3, 32'h33, 4'hF);
        rd(8'd1); rd(8'd2); rd(8'd3);
        idle(5);

        // Random traffic concentrated on a few addresses to force bypass collisions.
        for (int i = 0; i < 3000; i++) rand_cycle(16);
        idle(4);

        // Reset with two reads in flight.
        wr(8'd7, 32'h77777777, 4'hF); wr(8'd8, 32'h88888888, 4'hF);
        rd(8'd7); rd(8'd8);
        reset_dut();

        // Requests during the clear are ignored; afterwards memory reads back as zero.
        for (int i = 0; i < int'(DEPTH); i++) rand_cycle(256);
        rd(8'd7); rd(8'd8); rd(8'd0); rd(8'd255);
        for (int i = 0; i < 200; i++) rand_cycle(32);
        idle(5);

        check("scoreboard_drain", 32'(q1.size() + q3.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's dmem port. It is the memory-side end of the port the core drives as initiator: it accepts active-low chip-select write and read requests, applies byte-masked writes and returns read data after a fixed latency. After reset it zero-fills its storage. A side-band init port preloads data images before or between test runs. It replaces ad-hoc SRAM macros in simulation and FPGA builds.

## Interface
Parameters:
- ADDR_W, 8, word-address width (matches core dmem address)
- DATA_W, 32, data width; must be a multiple of 8
- DEPTH, 256, number of words; must be ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values are 1..3

Ports:
- clk_i  in  1  single clock; all logic rising-edge
- reset_i  in  1  asynchronous, active-low reset
- csb_write_i  in  1  write chip-select, active low
- wmask_i  in  DATA_W/8  byte write enables; bit b covers din[8b+7:8b]
- waddr_i  in  ADDR_W  write word address
- din_i  in  DATA_W  write data
- csb_read_i  in  1  read chip-select, active low
- raddr_i  in  ADDR_W  read word address
- dout_o  out  DATA_W  read data
- mem_ready_o  out  1  high once zero-fill is complete
- init_valid_i  in  1  preload write request
- init_ready_o  out  1  preload write accepted this cycle when high with valid
- init_addr_i  in  ADDR_W  preload word address
- init_data_i  in  DATA_W  preload data; always a full-word write

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with clr_ptr=0.
- CLEAR:
  - Writes 0 to word clr_ptr each cycle and increments clr_ptr.
  - After writing word DEPTH-1, moves to IDLE.
  - Takes exactly DEPTH cycles.
  - Core reads and writes and init requests are ignored; dout_o is held at 0.
- IDLE: mem_ready_o=1.
- Core write: when csb_write_i=0, update each byte b with wmask_i[b]=1 at waddr_i. A mask of 0 is a no-op.
- Init write:
  - init_ready_o = (state==IDLE) & csb_write_i. A core write has priority, so the two never collide.
  - A handshake (valid & ready) writes the full word.
- Read:
  - When csb_read_i=0 in IDLE, the address is sampled.
  - Data appears on dout_o RD_LAT cycles later.
  - When no read completes, dout_o holds its last value.
- Same-cycle read and write to the same address (core or init write): write-first. The returned data is the old word merged with the written bytes.
- Address ≥ DEPTH: writes are dropped and reads return 0.
- Reset mid-operation: in-flight reads are discarded, the pipeline valid bits clear, and CLEAR restarts from 0.

## Timing
- Reset values: dout_o=0, mem_ready_o=0, init_ready_o=0, all read-pipe valids=0.
- mem_ready_o rises in the cycle after the last CLEAR write, i.e. DEPTH cycles after reset deassertion.
- Writes are visible to reads sampled in the same edge (bypass) or later.
- The read pipeline accepts one read per cycle, giving full throughput at any RD_LAT.
- dout_o is registered. A read sampled at edge t drives dout_o from edge t+RD_LAT−1 onward (the RD_LAT=1 case is the standard synchronous SRAM).
- init_ready_o is combinational from state and csb_write_i. There is no combinational path from init_valid_i.

## Structure
- Package dmem_pkg holds:
  - the state enum (CLEAR, IDLE)
  - default ADDR_W, DATA_W, DEPTH, RD_LAT
  - a function byte_merge(old, new, mask) shared by the write path and the bypass
- Sub-module dmem_rd_pipe: a RD_LAT-deep valid/data shift pipeline with an async active-low reset on the valid bits. It is the natural split; the storage array and FSM stay in the top.

## Test plan
- Reset release, DEPTH=256 → mem_ready_o=0 for 256 cycles, then 1. Reading addresses 0, 128 and 255 returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with wmask 4'b1111, then write 0x000000AA with wmask 4'b0001 → reading addr 5 returns 0xDEADBEAA after RD_LAT cycles.
- Same-cycle write 0x12345678 (mask 4'b1100) and read of addr 9, which holds 0xAAAAAAAA → dout_o=0x1234AAAA.
- Hold csb_write_i=0 while init_valid_i=1 → init_ready_o=0 and the init is stalled. Release csb_write_i → init is accepted next cycle, and a later read of init_addr returns init_data.
- RD_LAT=3, back-to-back reads of addrs 1, 2, 3 holding 0x11, 0x22, 0x33 → dout_o shows 0x11, 0x22, 0x33 on three consecutive cycles starting 3 cycles after the first read.
- Assert reset_i=0 with two reads in flight → dout_o=0 immediately. After release, mem_ready_o=0 and memory rereads as 0 after the clear completes.
